// File: rtl/float_fixed_adder_tree_pipe.sv
// Pipelined reduction of NUM_ELEMENTS IEEE-754 singles into one saturated signed fixed-point sum.
// Convert stage, registered binary adder tree with growth bits, and a final clamp stage.
module float_fixed_adder_tree_pipe #(
  parameter int NUM_ELEMENTS     = 50,
  parameter int DATA_WIDTH_float = 32,
  parameter int DATA_WIDTH_fix   = 64,
  parameter int FRAC_BITS        = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH_float-1:0] AdderTree_in [NUM_ELEMENTS],
  output logic                        out_valid,
  output logic [DATA_WIDTH_fix-1:0]   AdderTree_out,
  output logic                        overflow,
  output logic                        invalid
);

  localparam int N      = NUM_ELEMENTS;
  localparam int W      = DATA_WIDTH_fix;
  localparam int LEVELS = $clog2(NUM_ELEMENTS);
  localparam int WL     = W + LEVELS;

  localparam logic [W-1:0]  FIX_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  FIX_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [WL-1:0] SUM_MAX = {{(LEVELS+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [WL-1:0] SUM_MIN = {{(LEVELS+1){1'b1}}, {(W-1){1'b0}}};

  // Number of live nodes at tree level k (odd leftovers pass through).
  function automatic int lvl_cnt(input int k);
    return (N + (1 << k) - 1) >> k;
  endfunction

  // Returns {nan, sat, value}. A normal operand whose mantissa would reach bit W-1
  // after shifting cannot fit, so the saturation test is a pure shift-amount compare.
  function automatic logic [W+1:0] to_fix(input logic [DATA_WIDTH_float-1:0] f);
    logic         s;
    logic [7:0]   e;
    logic [22:0]  m;
    logic [W-1:0] mag;
    logic [W-1:0] val;
    logic         nan;
    logic         sat;
    int           sh;
    s   = f[31];
    e   = f[30:23];
    m   = f[22:0];
    nan = 1'b0;
    sat = 1'b0;
    val = '0;
    mag = '0;
    sh  = int'(e) - 150 + FRAC_BITS;
    if (e == 8'd0) begin
      val = '0;
    end else if (e == 8'hFF) begin
      if (m != 23'd0) begin
        nan = 1'b1;
      end else begin
        sat = 1'b1;
        val = s ? FIX_MIN : FIX_MAX;
      end
    end else if (sh >= W - 24) begin
      sat = 1'b1;
      val = s ? FIX_MIN : FIX_MAX;
    end else begin
      if (sh >= 0) mag = W'({1'b1, m}) << sh;
      else         mag = W'({1'b1, m} >> (-sh));
      val = s ? (~mag + 1'b1) : mag;
    end
    return {nan, sat, val};
  endfunction

  logic [W-1:0] conv_d [N];
  logic         sat_d;
  logic         nan_d;

  always_comb begin
    logic [W+1:0] r;
    r     = '0;
    sat_d = 1'b0;
    nan_d = 1'b0;
    for (int i = 0; i < N; i++) begin
      r         = to_fix(AdderTree_in[i]);
      conv_d[i] = r[W-1:0];
      sat_d     = sat_d | r[W];
      nan_d     = nan_d | r[W+1];
    end
  end

  // Level 0 holds converted operands; level k holds partial sums. Every level is WL wide,
  // which covers the k growth bits each level needs. Row length 2N keeps pair indices in range.
  logic [WL-1:0] tree_q [LEVELS+1][2*N];
  logic [LEVELS:0] vld_q;
  logic [LEVELS:0] sat_q;
  logic [LEVELS:0] nan_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= LEVELS; k++)
        for (int i = 0; i < 2*N; i++)
          tree_q[k][i] <= '0;
      vld_q <= '0;
      sat_q <= '0;
      nan_q <= '0;
    end else begin
      vld_q <= {vld_q[LEVELS-1:0], in_valid};
      if (in_valid) begin
        for (int i = 0; i < N; i++)
          tree_q[0][i] <= WL'($signed(conv_d[i]));
        sat_q[0] <= sat_d;
        nan_q[0] <= nan_d;
      end
      for (int k = 1; k <= LEVELS; k++) begin
        if (vld_q[k-1]) begin
          sat_q[k] <= sat_q[k-1];
          nan_q[k] <= nan_q[k-1];
          for (int i = 0; i < N; i++) begin
            if (i < lvl_cnt(k)) begin
              if (2*i + 1 < lvl_cnt(k-1))
                tree_q[k][i] <= tree_q[k-1][2*i] + tree_q[k-1][2*i+1];
              else
                tree_q[k][i] <= tree_q[k-1][2*i];
            end
          end
        end
      end
    end
  end

  logic [WL-1:0] sum;
  logic [W-1:0]  clamp_d;
  logic          clamp_hit_d;

  assign sum = tree_q[LEVELS][0];

  always_comb begin
    clamp_d     = sum[W-1:0];
    clamp_hit_d = 1'b0;
    if ($signed(sum) > $signed(SUM_MAX)) begin
      clamp_d     = FIX_MAX;
      clamp_hit_d = 1'b1;
    end else if ($signed(sum) < $signed(SUM_MIN)) begin
      clamp_d     = FIX_MIN;
      clamp_hit_d = 1'b1;
    end
  end

  logic         out_valid_q;
  logic [W-1:0] out_q;
  logic         ovf_q;
  logic         inv_q;

  // Sum holds between vectors; flags are per-vector and drop when no vector is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      ovf_q       <= 1'b0;
      inv_q       <= 1'b0;
    end else begin
      out_valid_q <= vld_q[LEVELS];
      if (vld_q[LEVELS]) begin
        out_q <= clamp_d;
        ovf_q <= clamp_hit_d | sat_q[LEVELS];
        inv_q <= nan_q[LEVELS];
      end else begin
        ovf_q <= 1'b0;
        inv_q <= 1'b0;
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign AdderTree_out = out_q;
  assign overflow      = ovf_q;
  assign invalid       = inv_q;

endmodule
